// File: rtl/hit_arbiter.sv
// Hit event arbiter: captures per-player hit flags, arbitrates them round-robin
// and offers one event at a time to the health logic, with hit-stun lockout.
module hit_arbiter #(
    parameter int STUN_FRAMES = 20,
    parameter int BLOCK_STUN  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [1:0] p1_hit,
    input  logic [1:0] p2_hit,
    output logic       dmg_valid,
    output logic       dmg_target,
    output logic [1:0] dmg_kind,
    input  logic       dmg_ready,
    output logic       p1_stun,
    output logic       p2_stun,
    output logic       clash
);
    // state | meaning
    // IDLE  | no event offered; picks a pending player when one exists
    // OFFER | event held on dmg_* until dmg_ready completes the handshake
    typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

    localparam int MAX_STUN = (STUN_FRAMES > BLOCK_STUN) ? STUN_FRAMES : BLOCK_STUN;
    localparam int CW = $clog2(MAX_STUN + 1);
    localparam logic [CW-1:0] STUN_LD  = CW'(STUN_FRAMES);
    localparam logic [CW-1:0] BLOCK_LD = CW'(BLOCK_STUN);

    state_t                r_state, w_state_nxt;
    logic [1:0]            r_pend, w_pend_nxt;
    logic [1:0][1:0]       r_pend_kind, w_pend_kind_nxt;
    logic [1:0][CW-1:0]    r_cnt, w_cnt_nxt;
    logic                  r_rr, w_rr_nxt;
    logic                  r_valid, w_valid_nxt;
    logic                  r_target, w_target_nxt;
    logic [1:0]            r_kind, w_kind_nxt;
    logic                  r_clash, w_clash_nxt;

    logic [1:0][1:0]       w_hit;
    logic [1:0]            w_acc;
    logic [1:0]            w_tgt_oh;
    logic                  w_hs;
    logic                  w_sel;

    always_comb begin
        w_hit[0] = p1_hit;
        w_hit[1] = p2_hit;
        w_hs     = (r_state == OFFER) && dmg_ready;
        w_tgt_oh = {r_target, ~r_target};
        w_sel    = (&r_pend) ? r_rr : r_pend[1];

        w_state_nxt     = r_state;
        w_pend_nxt      = r_pend;
        w_pend_kind_nxt = r_pend_kind;
        w_cnt_nxt       = r_cnt;
        w_rr_nxt        = r_rr;
        w_valid_nxt     = r_valid;
        w_target_nxt    = r_target;
        w_kind_nxt      = r_kind;

        for (int i = 0; i < 2; i++) begin
            w_acc[i] = (w_hit[i] != 2'b00) && !r_pend[i] && (r_cnt[i] == '0);
            if (w_acc[i]) begin
                w_pend_nxt[i]      = 1'b1;
                w_pend_kind_nxt[i] = w_hit[i];
            end else if (w_hs && w_tgt_oh[i]) begin
                w_pend_nxt[i] = 1'b0;
            end
            if (w_hs && w_tgt_oh[i]) begin
                w_cnt_nxt[i] = (r_kind == 2'b11) ? BLOCK_LD : STUN_LD;
            end else if (r_cnt[i] != '0) begin
                w_cnt_nxt[i] = r_cnt[i] - CW'(1);
            end
        end
        w_clash_nxt = &w_acc;

        case (r_state)
            IDLE: begin
                if (|r_pend) begin
                    w_state_nxt  = OFFER;
                    w_valid_nxt  = 1'b1;
                    w_target_nxt = w_sel;
                    w_kind_nxt   = r_pend_kind[w_sel];
                end
            end
            OFFER: begin
                if (dmg_ready) begin
                    w_state_nxt = IDLE;
                    w_valid_nxt = 1'b0;
                    w_rr_nxt    = ~r_target;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Leaving the fight state discards everything, including a same-edge handshake.
        if (!enable) begin
            w_state_nxt = IDLE;
            w_pend_nxt  = '0;
            w_cnt_nxt   = '0;
            w_rr_nxt    = 1'b0;
            w_valid_nxt = 1'b0;
            w_clash_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pend      <= '0;
            r_pend_kind <= '0;
            r_cnt       <= '0;
            r_rr        <= 1'b0;
            r_valid     <= 1'b0;
            r_target    <= 1'b0;
            r_kind      <= 2'b00;
            r_clash     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pend      <= w_pend_nxt;
            r_pend_kind <= w_pend_kind_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rr        <= w_rr_nxt;
            r_valid     <= w_valid_nxt;
            r_target    <= w_target_nxt;
            r_kind      <= w_kind_nxt;
            r_clash     <= w_clash_nxt;
        end
    end

    assign dmg_valid  = r_valid;
    assign dmg_target = r_target;
    assign dmg_kind   = r_kind;
    assign p1_stun    = (r_cnt[0] != '0);
    assign p2_stun    = (r_cnt[1] != '0);
    assign clash      = r_clash;

endmodule

// File: tb/tb_hit_arbiter.sv
// Randomized and directed bench for hit_arbiter against a per-frame event model.
module tb_hit_arbiter;
    localparam int STUN = 20;
    localparam int BLK  = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] p1_hit = 2'b00;
    logic [1:0] p2_hit = 2'b00;
    logic       dmg_ready = 1'b0;
    logic       dmg_valid, dmg_target, p1_stun, p2_stun, clash;
    logic [1:0] dmg_kind;

    hit_arbiter #(.STUN_FRAMES(STUN), .BLOCK_STUN(BLK)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .p1_hit(p1_hit), .p2_hit(p2_hit),
        .dmg_valid(dmg_valid), .dmg_target(dmg_target), .dmg_kind(dmg_kind),
        .dmg_ready(dmg_ready),
        .p1_stun(p1_stun), .p2_stun(p2_stun), .clash(clash)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: who is waiting, remaining lockout frames, and the event on offer.
    bit m_pend[2];
    int m_pkind[2];
    int m_cnt[2];
    int m_rr;
    bit m_valid;
    int m_tgt;
    int m_kind;
    bit m_clash;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_pend[p] = 0; m_pkind[p] = 0; m_cnt[p] = 0;
        end
        m_rr = 0; m_valid = 0; m_tgt = 0; m_kind = 0; m_clash = 0;
    endtask

    task automatic model_edge(input bit en, input int h1, input int h2, input bit rdy);
        int  h[2];
        bit  acc[2];
        bit  npend[2];
        bit  hs;
        h[0] = h1; h[1] = h2;
        if (!en) begin
            for (int p = 0; p < 2; p++) begin m_pend[p] = 0; m_cnt[p] = 0; end
            m_rr = 0; m_valid = 0; m_clash = 0;
            return;
        end
        hs = m_valid && rdy;
        for (int p = 0; p < 2; p++)
            acc[p] = (h[p] != 0) && !m_pend[p] && (m_cnt[p] == 0);
        m_clash = acc[0] && acc[1];
        for (int p = 0; p < 2; p++) begin
            if (hs && m_tgt == p) m_cnt[p] = (m_kind == 3) ? BLK : STUN;
            else if (m_cnt[p] > 0) m_cnt[p] = m_cnt[p] - 1;
            npend[p] = m_pend[p];
        end
        if (hs) begin
            npend[m_tgt] = 0;
            m_valid = 0;
            m_rr = 1 - m_tgt;
        end else if (!m_valid && (m_pend[0] || m_pend[1])) begin
            m_tgt   = (m_pend[0] && m_pend[1]) ? m_rr : (m_pend[1] ? 1 : 0);
            m_kind  = m_pkind[m_tgt];
            m_valid = 1;
        end
        for (int p = 0; p < 2; p++) begin
            if (acc[p]) begin npend[p] = 1; m_pkind[p] = h[p]; end
            m_pend[p] = npend[p];
        end
    endtask

    task automatic compare_all();
        chk("dmg_valid", dmg_valid, m_valid);
        chk("p1_stun", p1_stun, m_cnt[0] != 0);
        chk("p2_stun", p2_stun, m_cnt[1] != 0);
        chk("clash", clash, m_clash);
        if (m_valid) begin
            chk("dmg_target", dmg_target, m_tgt);
            chk("dmg_kind", dmg_kind, m_kind);
        end
    endtask

    task automatic step(input bit en, input int h1, input int h2, input bit rdy);
        enable = en; p1_hit = 2'(h1); p2_hit = 2'(h2); dmg_ready = rdy;
        @(posedge clk);
        model_edge(en, h1, h2, rdy);
        #1;
        compare_all();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, dmg_valid, 0);
        chk({tag, "_target"}, dmg_target, 0);
        chk({tag, "_kind"}, dmg_kind, 0);
        chk({tag, "_stun"}, {p1_stun, p2_stun}, 0);
        chk({tag, "_clash"}, clash, 0);
    endtask

    int cnt_a, cnt_b;
    int tq[$];

    initial begin
        model_reset();
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step(1, 0, 0, 1);

        // single hit on P2, repeat hit during stun
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 30; i++) begin
            step(1, 0, (i == 0 || i == 8) ? 1 : 0, 1);
            if (p2_stun) cnt_a++;
            if (dmg_valid) cnt_b++;
        end
        chk("single_stun_len", cnt_a, STUN);
        chk("single_offers", cnt_b, 1);

        // clash
        cnt_a = 0; tq.delete();
        step(1, 2, 2, 1);
        if (clash) cnt_a++;
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0, 1);
            if (clash) cnt_a++;
            if (dmg_valid) tq.push_back(int'(dmg_target));
        end
        chk("clash_pulses", cnt_a, 1);
        chk("clash_grants", tq.size(), 2);
        if (tq.size() == 2) begin
            chk("clash_first", tq[0], 0);
            chk("clash_second", tq[1], 1);
        end
        for (int i = 0; i < 25; i++) step(1, 0, 0, 1);

        // backpressure with repeated flags from the held player
        step(1, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 2 + (i % 2), 0, 0);
        for (int i = 0; i < 25; i++) step(1, 0, 0, 1);

        // blocked hit
        cnt_a = 0;
        for (int i = 0; i < 15; i++) begin
            step(1, (i == 0) ? 3 : 0, 0, 1);
            if (p1_stun) cnt_a++;
        end
        chk("block_stun_len", cnt_a, BLK);

        // flush during offer with the other player pending, handshake discarded
        step(1, 1, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("flush_valid", dmg_valid, 0);
        step(1, 0, 0, 0);
        step(1, 2, 3, 1);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 1);
        for (int i = 0; i < 25; i++) step(1, 0, 0, 1);

        // random traffic with one asynchronous reset
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check_reset_outputs("async_reset");
                @(negedge clk);
                rst_n = 1'b1;
            end
            step(($urandom_range(0, 49) != 0),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                 $urandom_range(0, 1) == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
